fifo_feed_ctrl: RTL and testbench

//  Sequences a bank of DIM shift-register delay fifos (depth DEPTH) that feed the systolic array.

---
 rtl/fifo_feed_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_fifo_feed_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_feed_ctrl.sv
// fifo_feed_ctrl: sequences a bank of DIM shift-register delay fifos that feed
// the systolic array edge. In IDLE, host writes are steered into one lane at a
// time and per-lane fill is tracked. Once every lane is full, start drains all
// lanes with diagonal skew (lane i begins i cycles late) and presents
// zero-padded, valid-tagged data to the array.
// Optional build macro: FEED_CTRL_ERR_EN adds a sticky 'err' output that flags
// dropped writes and dropped start requests.
module fifo_feed_ctrl #(
    parameter int DIM   = 8,
    parameter int DEPTH = 8,
    parameter int BITS  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    input  logic [$clog2(DIM)-1:0]  wr_lane,
    input  logic [BITS-1:0]         wr_data,
    output logic                    wr_ready,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [DIM-1:0]          fifo_en,
    output logic [DIM*BITS-1:0]     fifo_d,
    input  logic [DIM*BITS-1:0]     fifo_q,
    output logic [DIM-1:0]          arr_valid,
    output logic [DIM*BITS-1:0]     arr_data
`ifdef FEED_CTRL_ERR_EN
    ,
    output logic                    err
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(DEPTH + DIM);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [TW-1:0] T_LAST   = TW'(DEPTH + DIM - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [TW-1:0]   t;
    logic [CW-1:0]   cnt [DIM];
    logic            all_full;
    int              t_int;

    // All-full is judged on registered counts, so a write landing in the same
    // cycle as start does not make that start valid.
    always_comb begin
        all_full = 1'b1;
        for (int i = 0; i < DIM; i++) begin
            if (cnt[i] != CNT_FULL) begin
                all_full = 1'b0;
            end
        end
    end

    // Next-state logic for the IDLE -> STREAM -> DONE -> IDLE sequence.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && all_full) next_state = STREAM;
            STREAM:  if (t == T_LAST)       next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register; async reset aborts any stream without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Stream counter and per-lane fill counts; counts clear once a stream ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t <= '0;
            for (int i = 0; i < DIM; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    t <= '0;
                    for (int i = 0; i < DIM; i++) begin
                        if (fifo_en[i]) begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                end
                STREAM: begin
                    t <= t + TW'(1);
                end
                DONE: begin
                    t <= '0;
                    for (int i = 0; i < DIM; i++) begin
                        cnt[i] <= '0;
                    end
                end
                default: t <= '0;
            endcase
        end
    end

    // Output decode: host write steering in IDLE, skewed drain in STREAM,
    // done pulse in DONE. Lanes at or beyond DIM never match, so they are refused.
    always_comb begin
        wr_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        fifo_en   = '0;
        fifo_d    = '0;
        arr_valid = '0;
        t_int     = 32'(t);
        case (state)
            IDLE: begin
                for (int i = 0; i < DIM; i++) begin
                    if (32'(wr_lane) == i) begin
                        wr_ready = (cnt[i] < CNT_FULL);
                        if (wr_valid && (cnt[i] < CNT_FULL)) begin
                            fifo_en[i]            = 1'b1;
                            fifo_d[i*BITS +: BITS] = wr_data;
                        end
                    end
                end
            end
            STREAM: begin
                busy = 1'b1;
                for (int i = 0; i < DIM; i++) begin
                    arr_valid[i] = (t_int >= i) && (t_int < i + DEPTH);
                end
                fifo_en = arr_valid;
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Array edge sees the fifo output only on lanes currently valid, else zero.
    always_comb begin
        arr_data = '0;
        for (int i = 0; i < DIM; i++) begin
            if (arr_valid[i]) begin
                arr_data[i*BITS +: BITS] = fifo_q[i*BITS +: BITS];
            end
        end
    end

`ifdef FEED_CTRL_ERR_EN
    logic bad_req;

    // A request is dropped when a write is refused, start comes before the bank
    // is full, or start arrives mid-stream.
    always_comb begin
        bad_req = 1'b0;
        if (state == IDLE) begin
            bad_req = (wr_valid && !wr_ready) || (start && !all_full);
        end else if (state == STREAM) begin
            bad_req = start;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (bad_req) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_feed_ctrl.sv
// tb_fifo_feed_ctrl: directed bench with a behavioural shift-register fifo
// bank and per-lane scoreboard queues of expected array-edge data.
module tb_fifo_feed_ctrl;

    localparam int DIM   = 4;
    localparam int DEPTH = 4;
    localparam int BITS  = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 wr_valid;
    logic [1:0]           wr_lane;
    logic [BITS-1:0]      wr_data;
    logic                 wr_ready;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [DIM-1:0]       fifo_en;
    logic [DIM*BITS-1:0]  fifo_d;
    logic [DIM*BITS-1:0]  fifo_q;
    logic [DIM-1:0]       arr_valid;
    logic [DIM*BITS-1:0]  arr_data;
`ifdef FEED_CTRL_ERR_EN
    logic                 err;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [BITS-1:0] sr [DIM][DEPTH];
    logic [BITS-1:0] exp_q [DIM][$];

    fifo_feed_ctrl #(.DIM(DIM), .DEPTH(DEPTH), .BITS(BITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_lane   (wr_lane),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fifo_en   (fifo_en),
        .fifo_d    (fifo_d),
        .fifo_q    (fifo_q),
        .arr_valid (arr_valid),
        .arr_data  (arr_data)
`ifdef FEED_CTRL_ERR_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural fifo bank: entry 0 newest, entry DEPTH-1 oldest.
    always @(posedge clk) begin
        for (int i = 0; i < DIM; i++) begin
            if (fifo_en[i]) begin
                for (int j = DEPTH - 1; j > 0; j--) begin
                    sr[i][j] <= sr[i][j-1];
                end
                sr[i][0] <= fifo_d[i*BITS +: BITS];
            end
        end
    end

    always_comb begin
        fifo_q = '0;
        for (int i = 0; i < DIM; i++) begin
            fifo_q[i*BITS +: BITS] = sr[i][DEPTH-1];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int lane, input logic [BITS-1:0] data, input bit exp_ok);
        wr_valid = 1'b1;
        wr_lane  = 2'(lane);
        wr_data  = data;
        #1;
        checkOutput("wr_ready", 64'(wr_ready), 64'(exp_ok));
        checkOutput("wr_fifo_en", 64'(fifo_en), exp_ok ? 64'(4'b0001 << lane) : 64'd0);
        if (exp_ok) begin
            checkOutput("wr_fifo_d", 64'(fifo_d[lane*BITS +: BITS]), 64'(data));
            exp_q[lane].push_back(data);
        end
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        #1;
        tick();
        start = 1'b0;
    endtask

    task automatic runStream(input bit inject, input bit check_t3);
        logic [DIM-1:0]  ev;
        logic [BITS-1:0] e;
        for (int t = 0; t < DEPTH + DIM - 1; t++) begin
            wr_valid = inject;
            wr_lane  = 2'd0;
            wr_data  = 8'hEE;
            start    = (t == 1);
            #1;
            checkOutput("stream_busy", 64'(busy), 64'd1);
            checkOutput("stream_done", 64'(done), 64'd0);
            ev = '0;
            for (int i = 0; i < DIM; i++) begin
                ev[i] = (t >= i) && (t < i + DEPTH);
            end
            checkOutput("arr_valid", 64'(arr_valid), 64'(ev));
            checkOutput("stream_fifo_en", 64'(fifo_en), 64'(ev));
            checkOutput("stream_fifo_d", 64'(fifo_d), 64'd0);
            if (inject) begin
                checkOutput("stream_wr_ready", 64'(wr_ready), 64'd0);
            end
            if (check_t3 && t == 3) begin
                checkOutput("arr_data_t3", 64'(arr_data), 64'h30211203);
            end
            for (int i = 0; i < DIM; i++) begin
                if (ev[i]) begin
                    checkOutput("sb_nonempty", 64'(exp_q[i].size() != 0), 64'd1);
                    e = (exp_q[i].size() != 0) ? exp_q[i].pop_front() : 8'h00;
                    checkOutput("arr_data_lane", 64'(arr_data[i*BITS +: BITS]), 64'(e));
                end else begin
                    checkOutput("arr_data_zero", 64'(arr_data[i*BITS +: BITS]), 64'd0);
                end
            end
            tick();
        end
        wr_valid = 1'b0;
        start    = 1'b0;
        #1;
        checkOutput("done_pulse", 64'(done), 64'd1);
        checkOutput("done_busy", 64'(busy), 64'd0);
        checkOutput("done_fifo_en", 64'(fifo_en), 64'd0);
        checkOutput("done_wr_ready", 64'(wr_ready), 64'd0);
        tick();
        checkOutput("after_done", 64'(done), 64'd0);
        checkOutput("after_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_lane  = 2'd0;
        wr_data  = '0;
        start    = 1'b0;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                sr[i][j] = '0;
            end
        end
        #12;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_fifo_en", 64'(fifo_en), 64'd0);
        checkOutput("rst_arr_valid", 64'(arr_valid), 64'd0);
        checkOutput("rst_arr_data", 64'(arr_data), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] basic load and skewed stream");
        for (int i = 0; i < DIM; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                applyStimulus(i, 8'(8'h10 * i + k), 1'b1);
            end
        end
        pulseStart();
        runStream(1'b0, 1'b1);

        $display("[TB] overflow and partial fill");
        for (int k = 0; k < DEPTH; k++) applyStimulus(2, 8'(8'hA8 + k), 1'b1);
        applyStimulus(2, 8'hFF, 1'b0);
        for (int k = 0; k < DEPTH; k++) applyStimulus(0, 8'(8'hA0 + k), 1'b1);
        for (int k = 0; k < DEPTH; k++) applyStimulus(1, 8'(8'hB4 + k), 1'b1);
        for (int k = 0; k < DEPTH - 1; k++) applyStimulus(3, 8'(8'hC0 + k), 1'b1);
        pulseStart();
        checkOutput("early_start_busy", 64'(busy), 64'd0);
        wr_lane = 2'd3;
        #1;
        checkOutput("lane3_ready", 64'(wr_ready), 64'd1);
        start = 1'b1;
        applyStimulus(3, 8'hC3, 1'b1);
        start = 1'b0;
        #1;
        checkOutput("same_cycle_start_busy", 64'(busy), 64'd0);
        pulseStart();
        runStream(1'b1, 1'b0);
        for (int i = 0; i < DIM; i++) begin
            wr_lane = 2'(i);
            #1;
            checkOutput("cnt_cleared_ready", 64'(wr_ready), 64'd1);
        end
        pulseStart();
        checkOutput("empty_start_busy", 64'(busy), 64'd0);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < DIM; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                applyStimulus(i, 8'(8'h50 + 8'h10 * i + k), 1'b1);
            end
        end
        pulseStart();
        tick();
        tick();
        checkOutput("pre_abort_busy", 64'(busy), 64'd1);
        checkOutput("pre_abort_valid", 64'(arr_valid), 64'b0111);
        rst_n = 1'b0;
        #1;
        tick();
        wr_lane = 2'd0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_fifo_en", 64'(fifo_en), 64'd0);
        checkOutput("abort_arr_valid", 64'(arr_valid), 64'd0);
        checkOutput("abort_wr_ready", 64'(wr_ready), 64'd1);
        checkOutput("abort_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < DIM; i++) exp_q[i].delete();
        for (int c = 0; c < DEPTH + DIM; c++) begin
            tick();
            checkOutput("no_done_after_abort", 64'(done), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
